// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives instruction memory, buffers {pc, instr}
// pairs in a small FIFO and hands them to decode over valid/ready.
module fetch_unit #(
  parameter int                        ADDR_BUS_WIDTH    = 13,
  parameter int                        INSTRUCTION_WIDTH = 34,
  parameter int                        QUEUE_DEPTH       = 2,
  parameter logic [ADDR_BUS_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         halt,
  output logic [ADDR_BUS_WIDTH-1:0]    imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
  input  logic                         redirect_valid,
  input  logic [ADDR_BUS_WIDTH-1:0]    redirect_addr,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_instr,
  output logic [ADDR_BUS_WIDTH-1:0]    fetch_pc,
  output logic [1:0]                   fetch_state
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [ADDR_BUS_WIDTH-1:0] PC_ONE = ADDR_BUS_WIDTH'(1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDR_BUS_WIDTH-1:0]    pc_q, pc_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [INSTRUCTION_WIDTH-1:0] buf_instr_q [QUEUE_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] buf_instr_d [QUEUE_DEPTH];
  logic [ADDR_BUS_WIDTH-1:0]    buf_pc_q [QUEUE_DEPTH];
  logic [ADDR_BUS_WIDTH-1:0]    buf_pc_d [QUEUE_DEPTH];
  logic                         valid_q, valid_d;
  logic [INSTRUCTION_WIDTH-1:0] head_instr_q, head_instr_d;
  logic [ADDR_BUS_WIDTH-1:0]    head_pc_q, head_pc_d;
  logic                         pop_s, push_s;
  logic [CW-1:0]                remain_s;

  // Run/halt control; the unused 11 encoding behaves like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (halt) state_d = HALTED;
        else      state_d = FETCH;
      end
      HALTED: begin
        if (run && !halt) state_d = FETCH;
        else              state_d = HALTED;
      end
      default: begin
        if (run && !halt) state_d = FETCH;
        else              state_d = IDLE;
      end
    endcase
  end

  // Queue, pc and registered head; the head is preloaded with whatever entry
  // will be at the front after this edge so outputs come straight from flops.
  always_comb begin
    pop_s        = valid_q && fetch_ready;
    push_s       = (state_q == FETCH) && !halt && !redirect_valid &&
                   ((count_q < DEPTH_C) || pop_s);
    remain_s     = count_q - CW'(pop_s);
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    if (redirect_valid) begin
      pc_d     = redirect_addr;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
      wr_ptr_d = wr_ptr_q + PW'(push_s);
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      if (push_s) begin
        buf_instr_d[wr_ptr_q] = imem_instr;
        buf_pc_d[wr_ptr_q]    = pc_q;
        pc_d                  = pc_q + PC_ONE;
      end else begin
        pc_d = pc_q;
      end
      if (remain_s != '0) begin
        head_instr_d = buf_instr_q[rd_ptr_d];
        head_pc_d    = buf_pc_q[rd_ptr_d];
      end else if (push_s) begin
        head_instr_d = imem_instr;
        head_pc_d    = pc_q;
      end else begin
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
      end
    end
    valid_d = (count_d != '0);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_valid = valid_q;
  assign fetch_instr = head_instr_q;
  assign fetch_pc    = head_pc_q;
  assign fetch_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit, checked every cycle against a
// queue-based reference model of the fetch stage.
module tb_fetch_unit;

  localparam int DEPTH  = 2;
  localparam int PC_MOD = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, halt;
  logic [12:0] imem_addr;
  logic [33:0] imem_instr;
  logic        redirect_valid;
  logic [12:0] redirect_addr;
  logic        fetch_valid, fetch_ready;
  logic [33:0] fetch_instr;
  logic [12:0] fetch_pc;
  logic [1:0]  fetch_state;

  int checks   = 0;
  int failures = 0;

  // reference model
  int          m_state;
  int          m_pc;
  logic [12:0] mq_pc[$];
  logic [33:0] mq_instr[$];

  fetch_unit dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] mem_f(input logic [12:0] a);
    return 34'(a) + 34'd100;
  endfunction

  assign imem_instr = mem_f(imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".valid"}, 64'(fetch_valid), 64'(mq_pc.size() != 0));
    chk({ctx, ".state"}, 64'(fetch_state), 64'(m_state));
    chk({ctx, ".imem_addr"}, 64'(imem_addr), 64'(m_pc));
    if (mq_pc.size() != 0) begin
      chk({ctx, ".head_pc"}, 64'(fetch_pc), 64'(mq_pc[0]));
      chk({ctx, ".head_instr"}, 64'(fetch_instr), 64'(mq_instr[0]));
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    mq_pc.delete();
    mq_instr.delete();
  endtask

  task automatic step(input string ctx, input bit r, input bit h, input bit rdy,
                      input bit rv, input int ra);
    bit pop, push;
    run            = r;
    halt           = h;
    fetch_ready    = rdy;
    redirect_valid = rv;
    redirect_addr  = 13'(ra);
    pop  = (mq_pc.size() != 0) && rdy;
    push = (m_state == 1) && !h && !rv && ((mq_pc.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (rv) begin
      mq_pc.delete();
      mq_instr.delete();
      m_pc = ra % PC_MOD;
    end else begin
      if (pop) begin
        mq_pc.delete(0);
        mq_instr.delete(0);
      end
      if (push) begin
        mq_pc.push_back(13'(m_pc));
        mq_instr.push_back(mem_f(13'(m_pc)));
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
    if (m_state == 1) m_state = h ? 2 : 1;
    else if (r && !h) m_state = 1;
    check_outputs(ctx);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; halt = 1'b0; fetch_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 13'd0;
    model_reset();
    #12;
    chk("reset.valid", 64'(fetch_valid), 64'd0);
    chk("reset.instr", 64'(fetch_instr), 64'd0);
    chk("reset.pc", 64'(fetch_pc), 64'd0);
    chk("reset.imem_addr", 64'(imem_addr), 64'd0);
    chk("reset.state", 64'(fetch_state), 64'd0);
    reset = 1'b0;

    step("idle", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    // straight-line fetch: valid two edges after run
    step("start1", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("start1.no_valid_yet", 64'(fetch_valid), 64'd0);
    step("start2", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("start2.first_pc", 64'(fetch_pc), 64'd0);
    chk("start2.first_instr", 64'(fetch_instr), 64'd100);
    for (int i = 0; i < 6; i++) step("stream", 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // backpressure from a fresh reset
    reset = 1'b1; #1; reset = 1'b0; model_reset();
    step("bp_start", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step("bp_hold", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("bp.addr_held", 64'(imem_addr), 64'd2);
    chk("bp.head_pc", 64'(fetch_pc), 64'd0);
    for (int i = 0; i < 5; i++) step("bp_release", 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // redirect with a full queue
    for (int i = 0; i < 3; i++) step("fill", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step("redir", 1'b1, 1'b0, 1'b1, 1'b1, 'h1A0);
    chk("redir.flushed", 64'(fetch_valid), 64'd0);
    step("redir_push", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    chk("redir.target_pc", 64'(fetch_pc), 64'h1A0);
    for (int i = 0; i < 3; i++) step("redir_run", 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // PC wrap-around
    step("wrap_redir", 1'b1, 1'b0, 1'b1, 1'b1, 8190);
    for (int i = 0; i < 5; i++) step("wrap", 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // halt with queued entries, drain, run+halt, resume
    for (int i = 0; i < 3; i++) step("hfill", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step("halt", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("halt.state", 64'(fetch_state), 64'd2);
    for (int i = 0; i < 3; i++) step("halt_drain", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    step("halt_and_run", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step("resume", 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int ra;
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8188, 8191))
                                       : int'($urandom_range(0, 8191));
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, ra);
    end

    // asynchronous reset between edges with a full queue
    step("ar_redir", 1'b1, 1'b0, 1'b0, 1'b1, 300);
    for (int i = 0; i < 3; i++) step("ar_fill", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset.valid", 64'(fetch_valid), 64'd0);
    chk("async_reset.imem_addr", 64'(imem_addr), 64'd0);
    chk("async_reset.state", 64'(fetch_state), 64'd0);
    model_reset();
    #10;
    reset = 1'b0;
    step("post_reset_idle", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step("post_reset_run", 1'b1, 1'b0, 1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
